// File: rtl/disparity_frame_sequencer.sv
// Frame-level sequencer for the min-disparity core: raster walk, result tagging,
// left-edge zeroing and a credit-protected write FIFO toward the disparity map.
module disparity_frame_sequencer #(
    parameter int unsigned IMG_W      = 640,
    parameter int unsigned IMG_H      = 480,
    parameter int unsigned DMAX_COLS  = 32,
    parameter int unsigned CORE_LAT   = 1,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned ADDR_W     = 19
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic              i_pix_valid,
    output logic              o_pix_ready,
    output logic              o_core_valid,
    input  logic              i_core_valid,
    input  logic [7:0]        i_core_disp,
    output logic              o_wr_valid,
    output logic [ADDR_W-1:0] o_wr_addr,
    output logic [7:0]        o_wr_data,
    input  logic              i_wr_ready,
    output logic              o_busy,
    output logic              o_frame_done,
    output logic              o_err
);

    localparam int unsigned XW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int unsigned YW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = PW + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // Tag travelling alongside a pixel through the core.
    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] addr;
        logic              edge_col;
    } tag_t;

    // One buffered write toward the disparity-map memory.
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [7:0]        data;
    } wr_t;

    state_t            state_q, state_d;
    logic [XW-1:0]     x_q, x_d;
    logic [YW-1:0]     y_q, y_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    tag_t              tag_q [CORE_LAT];
    tag_t              tag_d [CORE_LAT];
    wr_t               mem_q [FIFO_DEPTH];
    wr_t               mem_d [FIFO_DEPTH];
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [CW-1:0]     out_q, out_d;
    logic              err_q, err_d;

    logic              pix_ready_c;
    logic              issue_c;
    logic              pop_c;
    logic              push_c;
    logic              fifo_full_c;
    logic              last_pix_c;
    tag_t              tag_out_c;

    // Handshake decode: credits gate acceptance, core never stalls.
    always_comb begin
        pix_ready_c = (state_q == S_RUN) && (out_q < CW'(FIFO_DEPTH));
        issue_c     = pix_ready_c && i_pix_valid;
        tag_out_c   = tag_q[CORE_LAT-1];
        fifo_full_c = (cnt_q == CW'(FIFO_DEPTH));
        pop_c       = (cnt_q != '0) && i_wr_ready;
        push_c      = i_core_valid && tag_out_c.valid && (!fifo_full_c || pop_c);
        last_pix_c  = (x_q == XW'(IMG_W - 1)) && (y_q == YW'(IMG_H - 1));
    end

    // Frame FSM: next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (i_start) state_d = S_RUN;
            S_RUN:   if (issue_c && last_pix_c) state_d = S_DRAIN;
            S_DRAIN: if (out_q == '0) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Raster position and incremental write address.
    always_comb begin
        x_d    = x_q;
        y_d    = y_q;
        addr_d = addr_q;
        if ((state_q == S_IDLE) && i_start) begin
            x_d    = '0;
            y_d    = '0;
            addr_d = '0;
        end else if (issue_c) begin
            if (x_q == XW'(IMG_W - 1)) begin
                x_d = '0;
                y_d = y_q + YW'(1);
            end else begin
                x_d = x_q + XW'(1);
            end
            addr_d = addr_q + ADDR_W'(1);
        end
    end

    // Tag shift register, aligned with the core's fixed latency.
    always_comb begin
        tag_d[0].valid    = issue_c;
        tag_d[0].addr     = addr_q;
        tag_d[0].edge_col = (32'(x_q) < DMAX_COLS);
        for (int unsigned i = 1; i < CORE_LAT; i++) begin
            tag_d[i] = tag_q[i-1];
        end
    end

    // Result FIFO: tagged push from the core, pop toward memory.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push_c) begin
            mem_d[wr_ptr_q].addr = tag_out_c.addr;
            mem_d[wr_ptr_q].data = tag_out_c.edge_col ? 8'd0 : i_core_disp;
            wr_ptr_d             = wr_ptr_q + PW'(1);
        end
        if (pop_c) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({push_c, pop_c})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // Outstanding credits and sticky protocol error.
    always_comb begin
        out_d = out_q;
        if (issue_c && !pop_c) begin
            out_d = out_q + CW'(1);
        end else if (!issue_c && pop_c) begin
            out_d = out_q - CW'(1);
        end
        err_d = err_q
              | (i_core_valid != tag_out_c.valid)
              | (i_core_valid && tag_out_c.valid && fifo_full_c && !pop_c);
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q  <= S_IDLE;
            x_q      <= '0;
            y_q      <= '0;
            addr_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            out_q    <= '0;
            err_q    <= 1'b0;
            for (int unsigned i = 0; i < CORE_LAT; i++) begin
                tag_q[i] <= '0;
            end
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            y_q      <= y_d;
            addr_q   <= addr_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            out_q    <= out_d;
            err_q    <= err_d;
            tag_q    <= tag_d;
            mem_q    <= mem_d;
        end
    end

    // Output decode from registered state.
    always_comb begin
        o_pix_ready  = pix_ready_c;
        o_core_valid = issue_c;
        o_wr_valid   = (cnt_q != '0);
        o_wr_addr    = mem_q[rd_ptr_q].addr;
        o_wr_data    = mem_q[rd_ptr_q].data;
        o_busy       = (state_q != S_IDLE);
        o_frame_done = (state_q == S_DONE);
        o_err        = err_q;
    end

endmodule

// File: tb/tb_disparity_frame_sequencer.sv
// Randomized scoreboard bench for disparity_frame_sequencer with a small core model.
module tb_disparity_frame_sequencer;

    localparam int W   = 4;
    localparam int H   = 2;
    localparam int DM  = 2;
    localparam int LAT = 1;
    localparam int FD  = 4;
    localparam int AW  = 19;

    logic          clk      = 1'b0;
    logic          rst_n    = 1'b0;
    logic          start    = 1'b0;
    logic          pv       = 1'b0;
    logic          wr_ready = 1'b0;
    logic          inj      = 1'b0;
    logic          core_v   = 1'b0;
    logic [7:0]    core_d   = 8'd0;
    logic          pix_ready;
    logic          core_valid_o;
    logic          wr_valid;
    logic [AW-1:0] wr_addr;
    logic [7:0]    wr_data;
    logic          busy;
    logic          frame_done;
    logic          err;

    int n_chk     = 0;
    int n_pass    = 0;
    int done_cnt  = 0;
    int issue_cnt = 0;
    int exp_idx   = 0;
    int px        = 0;

    typedef struct {
        int addr;
        int data;
    } exp_t;
    exp_t sb[$];

    disparity_frame_sequencer #(
        .IMG_W(W), .IMG_H(H), .DMAX_COLS(DM), .CORE_LAT(LAT),
        .FIFO_DEPTH(FD), .ADDR_W(AW)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_start      (start),
        .i_pix_valid  (pv),
        .o_pix_ready  (pix_ready),
        .o_core_valid (core_valid_o),
        .i_core_valid (core_v | inj),
        .i_core_disp  (core_d),
        .o_wr_valid   (wr_valid),
        .o_wr_addr    (wr_addr),
        .o_wr_data    (wr_data),
        .i_wr_ready   (wr_ready),
        .o_busy       (busy),
        .o_frame_done (frame_done),
        .o_err        (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Core model: fixed one-cycle latency, returns 8*(x+1) for the pixel it was given.
    always @(posedge clk) begin
        if (!rst_n) begin
            core_v <= 1'b0;
            core_d <= 8'd0;
            px     <= 0;
        end else begin
            core_v <= core_valid_o;
            core_d <= 8'(8 * ((px % W) + 1));
            if (core_valid_o) px <= px + 1;
        end
    end

    // Scoreboard: record expected writes on issue, compare on every pop.
    initial begin
        exp_t e;
        int   x;
        forever begin
            @(negedge clk);
            #1;
            if (rst_n) begin
                if (core_valid_o) begin
                    x = exp_idx % W;
                    e.addr = exp_idx;
                    e.data = (x < DM) ? 0 : 8 * (x + 1);
                    sb.push_back(e);
                    exp_idx++;
                    issue_cnt++;
                end
                if (wr_valid && wr_ready) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_write", int'(wr_addr), -1);
                    end else begin
                        e = sb.pop_front();
                        chk("wr_addr", int'(wr_addr), e.addr);
                        chk("wr_data", int'(wr_data), e.data);
                    end
                end
                if (frame_done) begin
                    done_cnt++;
                    chk("sb_empty_at_done", sb.size(), 0);
                end
            end
        end
    end

    task automatic check_zero(input string tag);
        chk({tag, "_pix_ready"},  int'(pix_ready),    0);
        chk({tag, "_core_valid"}, int'(core_valid_o), 0);
        chk({tag, "_wr_valid"},   int'(wr_valid),     0);
        chk({tag, "_wr_addr"},    int'(wr_addr),      0);
        chk({tag, "_wr_data"},    int'(wr_data),      0);
        chk({tag, "_busy"},       int'(busy),         0);
        chk({tag, "_frame_done"}, int'(frame_done),   0);
        chk({tag, "_err"},        int'(err),          0);
    endtask

    task automatic wait_done(input int d0, input string tag);
        int cyc = 0;
        while (done_cnt == d0 && cyc < 3000) begin
            @(negedge clk);
            cyc++;
        end
        chk({tag, "_frame_done"}, done_cnt - d0, 1);
    endtask

    task automatic post_frame(input int d0, input string tag);
        pv       = 1'b0;
        wr_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk({tag, "_single_done"}, done_cnt - d0, 1);
        chk({tag, "_idle"},        int'(busy),    0);
        chk({tag, "_no_err"},      int'(err),     0);
        chk({tag, "_issues"},      exp_idx,       W * H);
    endtask

    task automatic run_frame(input int pv_pct, input int wr_pct, input bit mid_start,
                             input string tag);
        int d0;
        int cyc;
        int busy_low;
        exp_idx = 0;
        pv      = 1'b0;
        start   = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        d0       = done_cnt;
        cyc      = 0;
        busy_low = 0;
        while (done_cnt == d0 && cyc < 3000) begin
            if (!busy) busy_low++;
            pv       = (int'($urandom_range(99)) < pv_pct);
            wr_ready = (int'($urandom_range(99)) < wr_pct);
            start    = mid_start && (cyc == 2 || cyc == 5);
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        chk({tag, "_frame_done"}, done_cnt - d0, 1);
        chk({tag, "_busy_in_frame"}, busy_low, 0);
        post_frame(d0, tag);
    endtask

    initial begin
        int base;
        int rdy;
        int d0;
        int cyc;

        // Reset state
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // T1: full-rate frame
        run_frame(100, 100, 1'b0, "t1");

        // T2/T3: backpressure fills FIFO, then steady issue/pop
        exp_idx  = 0;
        pv       = 1'b0;
        wr_ready = 1'b0;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        d0    = done_cnt;
        pv    = 1'b1;
        base  = issue_cnt;
        repeat (10) @(negedge clk);
        chk("t2_issues", issue_cnt - base, 4);
        chk("t2_pix_ready", int'(pix_ready), 0);
        wr_ready = 1'b1;
        base     = issue_cnt;
        rdy      = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (i < 4) rdy += int'(pix_ready);
        end
        chk("t3_pix_ready_cycles", rdy, 4);
        chk("t3_issues", issue_cnt - base, 4);
        wait_done(d0, "t3");
        post_frame(d0, "t3");

        // T4: start pulsed mid-frame is ignored
        run_frame(100, 100, 1'b1, "t4");

        // Randomized traffic
        for (int k = 0; k < 4; k++) begin
            run_frame(60, 50, k[0], "rnd");
        end

        // T5: reset mid-frame, then a clean frame
        exp_idx  = 0;
        pv       = 1'b0;
        wr_ready = 1'b1;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        pv    = 1'b1;
        base  = issue_cnt;
        cyc   = 0;
        while (issue_cnt - base < 5 && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        chk("t5_issues_before_reset", issue_cnt - base, 5);
        rst_n = 1'b0;
        sb.delete();
        @(negedge clk);
        check_zero("t5_reset");
        rst_n = 1'b1;
        pv    = 1'b0;
        @(negedge clk);
        run_frame(100, 100, 1'b0, "t5");

        // T6: spurious core result in IDLE sets sticky error
        inj = 1'b1;
        @(negedge clk);
        inj = 1'b0;
        chk("t6_err_set", int'(err), 1);
        chk("t6_wr_valid", int'(wr_valid), 0);
        chk("t6_busy", int'(busy), 0);
        repeat (4) @(negedge clk);
        chk("t6_err_hold", int'(err), 1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("t6_err_cleared", int'(err), 0);
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    // Global time bound
    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule
